// File: rtl/sb_mem_arbiter.sv
// Two-master (core, debug system bus) to one-slave arbiter for a req/gnt/rvalid bus.
// In-order responses are steered back to their issuer through a small owner-ID FIFO.
module sb_mem_arbiter #(
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [AddrWidth-1:0]   core_addr,
  input  logic [DataWidth/8-1:0] core_be,
  input  logic [DataWidth-1:0]   core_wdata,
  output logic                   core_gnt,
  output logic                   core_rvalid,
  output logic [DataWidth-1:0]   core_rdata,
  input  logic                   sb_req,
  input  logic                   sb_we,
  input  logic [AddrWidth-1:0]   sb_addr,
  input  logic [DataWidth/8-1:0] sb_be,
  input  logic [DataWidth-1:0]   sb_wdata,
  output logic                   sb_gnt,
  output logic                   sb_rvalid,
  output logic [DataWidth-1:0]   sb_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AddrWidth-1:0]   mem_addr,
  output logic [DataWidth/8-1:0] mem_be,
  output logic [DataWidth-1:0]   mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [DataWidth-1:0]   mem_rdata,
  output logic                   err_spurious
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic OwnerCore = 1'b0;
  localparam logic OwnerSb   = 1'b1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                    state_q, state_d;
  logic                      lock_owner_q, lock_owner_d;
  logic                      last_owner_q, last_owner_d;
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      full_q, full_d;
  logic                      err_q, err_d;

  logic owner;
  logic owner_req;
  logic transfer;
  logic empty;
  logic pop;
  logic head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) ptr_inc = '0;
    else                                ptr_inc = p + PtrW'(1);
  endfunction

  // Owner selection and zero-latency request pass-through; full blocks everything.
  always_comb begin
    owner = OwnerCore;
    if (state_q == LOCKED)         owner = lock_owner_q;
    else if (core_req && sb_req)   owner = ~last_owner_q;
    else if (sb_req && !core_req)  owner = OwnerSb;

    owner_req = (owner == OwnerSb) ? sb_req : core_req;
    mem_req   = owner_req & ~full_q;
    transfer  = mem_req & mem_gnt;
    core_gnt  = transfer & (owner == OwnerCore);
    sb_gnt    = transfer & (owner == OwnerSb);

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_we    = (owner == OwnerSb) ? sb_we    : core_we;
      mem_addr  = (owner == OwnerSb) ? sb_addr  : core_addr;
      mem_be    = (owner == OwnerSb) ? sb_be    : core_be;
      mem_wdata = (owner == OwnerSb) ? sb_wdata : core_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    last_owner_d = transfer ? owner : last_owner_q;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_gnt) begin
          state_d      = LOCKED;
          lock_owner_d = owner;
        end
      end
      LOCKED: begin
        if (transfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner FIFO: every transfer pushes, every answered rvalid pops the head.
  always_comb begin
    empty    = (count_q == '0);
    pop      = mem_rvalid & ~empty;
    head     = fifo_q[rd_ptr_q];
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (transfer) begin
      fifo_d[wr_ptr_q] = owner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (transfer && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !transfer) count_d = count_q - CntW'(1);
    full_d = (count_d == CntW'(MaxOutstanding));
    err_d  = err_q | (mem_rvalid & empty);

    core_rvalid = pop & (head == OwnerCore);
    sb_rvalid   = pop & (head == OwnerSb);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    sb_rdata    = sb_rvalid   ? mem_rdata : '0;
    err_spurious = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lock_owner_q <= OwnerCore;
      last_owner_q <= OwnerSb;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      last_owner_q <= last_owner_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_sb_mem_arbiter.sv
// Self-checking bench for sb_mem_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based model of the arbitration and response-routing rules.
module tb_sb_mem_arbiter;

  localparam int M  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW/8-1:0] core_be;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          sb_req, sb_we, sb_gnt, sb_rvalid;
  logic [AW-1:0] sb_addr;
  logic [DW/8-1:0] sb_be;
  logic [DW-1:0] sb_wdata, sb_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          err_spurious;

  always #5 clk = ~clk;

  sb_mem_arbiter #(.MaxOutstanding(M), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_be(core_be),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .sb_req(sb_req), .sb_we(sb_we), .sb_addr(sb_addr), .sb_be(sb_be),
    .sb_wdata(sb_wdata), .sb_gnt(sb_gnt), .sb_rvalid(sb_rvalid), .sb_rdata(sb_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_spurious(err_spurious)
  );

  // Reference model: 0 = core, 1 = debug system bus
  int  lastOwner;
  bit  locked;
  int  lockOwner;
  int  ownerQ[$];
  bit  errSticky;

  int          eOwner;
  bit          eMemReq, eCoreGnt, eSbGnt, eCoreRv, eSbRv, hasResp;
  logic        eWe;
  logic [AW-1:0] eAddr;
  logic [DW/8-1:0] eBe;
  logic [DW-1:0] eWdata, eCoreRdata, eSbRdata;

  logic        sMemReq, sCoreGnt, sSbGnt, sCoreRv, sSbRv, sErr;
  logic [AW-1:0] sMemAddr;
  logic [DW-1:0] sCoreRdata, sSbRdata;

  int testsRun  = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic sReq, input logic gnt,
                               input logic rv, input logic [DW-1:0] rdata);
    core_req   = cReq;
    sb_req     = sReq;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rdata;
  endtask

  task automatic modelReset();
    lastOwner = 1;
    locked    = 0;
    lockOwner = 0;
    ownerQ.delete();
    errSticky = 0;
  endtask

  task automatic computeExpected();
    bit full, ownerReq;
    full = (ownerQ.size() >= M);
    if (locked)                      eOwner = lockOwner;
    else if (core_req && sb_req)     eOwner = 1 - lastOwner;
    else                             eOwner = (sb_req && !core_req) ? 1 : 0;
    ownerReq = (eOwner == 1) ? sb_req : core_req;
    eMemReq  = ownerReq && !full;
    eWe    = eMemReq ? ((eOwner == 1) ? sb_we    : core_we)    : 1'b0;
    eAddr  = eMemReq ? ((eOwner == 1) ? sb_addr  : core_addr)  : '0;
    eBe    = eMemReq ? ((eOwner == 1) ? sb_be    : core_be)    : '0;
    eWdata = eMemReq ? ((eOwner == 1) ? sb_wdata : core_wdata) : '0;
    eCoreGnt = eMemReq && mem_gnt && (eOwner == 0);
    eSbGnt   = eMemReq && mem_gnt && (eOwner == 1);
    hasResp  = mem_rvalid && (ownerQ.size() > 0);
    eCoreRv  = hasResp && (ownerQ[0] == 0);
    eSbRv    = hasResp && (ownerQ[0] == 1);
    eCoreRdata = eCoreRv ? mem_rdata : '0;
    eSbRdata   = eSbRv   ? mem_rdata : '0;
  endtask

  task automatic checkAll();
    checkOutput("mem_req", mem_req, eMemReq);
    checkOutput("mem_we", mem_we, eWe);
    checkOutput("mem_addr", mem_addr, eAddr);
    checkOutput("mem_be", mem_be, eBe);
    checkOutput("mem_wdata", mem_wdata, eWdata);
    checkOutput("core_gnt", core_gnt, eCoreGnt);
    checkOutput("sb_gnt", sb_gnt, eSbGnt);
    checkOutput("core_rvalid", core_rvalid, eCoreRv);
    checkOutput("sb_rvalid", sb_rvalid, eSbRv);
    checkOutput("core_rdata", core_rdata, eCoreRdata);
    checkOutput("sb_rdata", sb_rdata, eSbRdata);
    checkOutput("err_spurious", err_spurious, errSticky);
  endtask

  task automatic updateModel();
    if (hasResp) void'(ownerQ.pop_front());
    else if (mem_rvalid) errSticky = 1;
    if (eMemReq && mem_gnt) begin
      ownerQ.push_back(eOwner);
      lastOwner = eOwner;
    end
    if (!locked && eMemReq && !mem_gnt) begin
      locked    = 1;
      lockOwner = eOwner;
    end else if (locked && eMemReq && mem_gnt) begin
      locked = 0;
    end
  endtask

  // Called 1 time unit after a rising edge: check at the falling edge, then advance.
  task automatic runCycle();
    #4;
    computeExpected();
    sMemReq = mem_req;  sMemAddr = mem_addr;
    sCoreGnt = core_gnt; sSbGnt = sb_gnt;
    sCoreRv = core_rvalid; sSbRv = sb_rvalid;
    sCoreRdata = core_rdata; sSbRdata = sb_rdata;
    sErr = err_spurious;
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, '0);
    modelReset();
    #4;
    computeExpected();
    checkAll();
    checkOutput("reset_err", err_spurious, 1'b0);
    checkOutput("reset_mem_req", mem_req, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    applyStimulus(0, 0, 0, 0, '0);
    for (int n = 0; n < 2 * M + 2 && ownerQ.size() > 0; n++) begin
      applyStimulus(0, 0, 0, 1, $urandom);
      runCycle();
    end
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("drain_empty", ownerQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    core_we = 0; core_addr = 32'h0000_1000; core_be = 4'hF; core_wdata = 32'hC0C0_0001;
    sb_we   = 1; sb_addr   = 32'h0000_2000; sb_be   = 4'h3; sb_wdata   = 32'h5B5B_0001;
    doReset();

    // Round-robin with both masters always requesting; responses one cycle behind
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k < 4, k < 4, 1, k > 0, 32'hA0 + k - 1);
      core_addr = 32'h1000 + k; sb_addr = 32'h2000 + k;
      runCycle();
      if (k < 4) begin
        checkOutput("rr_core_gnt", sCoreGnt, (k % 2) == 0);
        checkOutput("rr_sb_gnt", sSbGnt, (k % 2) == 1);
      end
      if (k > 0)
        checkOutput("rr_rdata", (k % 2 == 1) ? sCoreRdata : sSbRdata, 32'hA0 + k - 1);
    end

    // Lock: sb stalls, core arrives mid-stall and must not pre-empt
    sb_addr = 32'h0000_2ABC; core_addr = 32'h0000_1ABC;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k >= 1, 1, 0, 0, '0);
      runCycle();
      checkOutput("lock_addr", sMemAddr, 32'h0000_2ABC);
    end
    applyStimulus(1, 1, 1, 0, '0);
    runCycle();
    checkOutput("lock_sb_gnt", sSbGnt, 1'b1);
    checkOutput("lock_core_held", sCoreGnt, 1'b0);
    applyStimulus(1, 1, 1, 1, 32'h55);
    runCycle();
    checkOutput("after_lock_core_wins", sCoreGnt, 1'b1);
    checkOutput("after_lock_sb_rv", sSbRv, 1'b1);
    applyStimulus(0, 1, 1, 0, '0);
    runCycle();
    drain();

    // Full: two outstanding block the third until one response has been seen
    applyStimulus(1, 0, 1, 0, '0); runCycle();
    applyStimulus(0, 1, 1, 0, '0); runCycle();
    applyStimulus(1, 0, 1, 0, '0); runCycle();
    checkOutput("full_blocks", sMemReq, 1'b0);
    checkOutput("full_no_gnt", sCoreGnt, 1'b0);
    applyStimulus(1, 0, 1, 1, 32'h77); runCycle();
    checkOutput("full_still_blocked", sMemReq, 1'b0);
    checkOutput("full_pop_core", sCoreRv, 1'b1);
    applyStimulus(1, 0, 1, 0, '0); runCycle();
    checkOutput("full_reassert", sMemReq, 1'b1);
    checkOutput("full_core_gnt", sCoreGnt, 1'b1);
    drain();

    // Ordering: core read, then sb write, responses in order
    core_we = 0; sb_we = 1;
    applyStimulus(1, 0, 1, 0, '0); runCycle();
    applyStimulus(0, 1, 1, 0, '0); runCycle();
    applyStimulus(0, 0, 0, 1, 32'h1234); runCycle();
    checkOutput("order_core_rv", sCoreRv, 1'b1);
    checkOutput("order_core_rdata", sCoreRdata, 32'h1234);
    checkOutput("order_sb_quiet", sSbRv, 1'b0);
    applyStimulus(0, 0, 0, 1, 32'h9999); runCycle();
    checkOutput("order_sb_rv", sSbRv, 1'b1);
    checkOutput("order_core_quiet", sCoreRv, 1'b0);

    // Spurious response with nothing outstanding
    applyStimulus(0, 0, 0, 1, 32'hDEAD); runCycle();
    checkOutput("spur_no_core_rv", sCoreRv, 1'b0);
    checkOutput("spur_no_sb_rv", sSbRv, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, '0); runCycle();
      checkOutput("spur_sticky", sErr, 1'b1);
    end
    doReset();

    // Reset with a transaction outstanding: its late response is spurious
    applyStimulus(1, 0, 1, 0, '0); runCycle();
    doReset();
    applyStimulus(0, 0, 0, 1, 32'hBEEF); runCycle();
    checkOutput("postreset_no_rv", sCoreRv, 1'b0);
    applyStimulus(0, 0, 0, 0, '0); runCycle();
    checkOutput("postreset_err", sErr, 1'b1);
    doReset();

    // Random traffic obeying the hold-until-grant protocol
    for (int k = 0; k < 300; k++) begin
      if (!core_req && ($urandom % 2 == 1)) begin
        core_req = 1; core_we = $urandom; core_addr = $urandom;
        core_be = $urandom; core_wdata = $urandom;
      end
      if (!sb_req && ($urandom % 2 == 1)) begin
        sb_req = 1; sb_we = $urandom; sb_addr = $urandom;
        sb_be = $urandom; sb_wdata = $urandom;
      end
      mem_gnt    = ($urandom % 10) < 6;
      mem_rvalid = (ownerQ.size() > 0) && ($urandom % 2 == 1);
      mem_rdata  = $urandom;
      runCycle();
      if (eCoreGnt) core_req = 0;
      if (eSbGnt)   sb_req   = 0;
    end
    doReset();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
